sequence_generator: RTL and testbench



---
 rtl/sequence_generator_pkg.sv | 33 +++
 rtl/sequence_generator_lfsr16.sv | 35 +++
 rtl/sequence_generator.sv | 96 +++++++++
 tb/tb_sequence_generator.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sequence_generator_pkg.sv
// Shared types and constants for the memory-game sequence generator and its LFSR.
package sequence_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  localparam logic [15:0] LFSR_MASK  = 16'hB400;
  localparam int          MAX_LEN    = 32;
  localparam int          DIGIT_BASE = 10;

  // Folds the 16 nibble codes onto 0..9; codes 10..15 land on 4..9.
  function automatic logic [3:0] lfsr_digit(input logic [15:0] v);
    logic [3:0] n;
    n = v[3:0];
    if (n >= 4'(DIGIT_BASE)) begin
      return n - 4'(16 - DIGIT_BASE);
    end
    return n;
  endfunction

  function automatic logic [6:0] calc_len(input logic [3:0] diff);
    logic [6:0] raw;
    raw = ({3'b000, diff} + 7'd1) << 2;
    if (raw > 7'(MAX_LEN)) begin
      return 7'(MAX_LEN);
    end
    return raw;
  endfunction

endpackage

// File: rtl/sequence_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR; also usable by the controller for tie-breaks.
module sequence_generator_lfsr16
  import sequence_generator_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_sys_i,
  input  logic        rst_b_i,
  output logic [15:0] q_o
);

  // An all-zero state would lock the register up, so it is never loaded.
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ LFSR_MASK;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_b_i) begin
      lfsr_q <= SEED_NZ;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/sequence_generator.sv
// Writes one round of random decimal digits to the sequence RAM, answering the
// controller's GoGen/FinGen four-phase handshake.
//
// state    | meaning
// ST_IDLE  | waiting for GoGen, nothing driven
// ST_WRITE | one RAM write per cycle, addresses 0..SeqLen-1
// ST_DONE  | FinGen high until GoGen drops
module sequence_generator
  import sequence_generator_pkg::*;
#(
  parameter int          ADDR_W  = 5,
  parameter int          DIGIT_W = 4,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic              clk_sys_i,
  input  logic              rst_b_i,
  input  logic              go_gen_i,
  input  logic [3:0]        diff_i,
  output logic              fin_gen_o,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DIGIT_W-1:0] ram_data_o,
  output logic [ADDR_W:0]   seq_len_o
);

  localparam int LEN_W = ADDR_W + 1;

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  seq_len_q, seq_len_d;
  logic [15:0]       lfsr_q;
  logic              last_write;

  sequence_generator_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk_sys_i (clk_sys_i),
    .rst_b_i   (rst_b_i),
    .q_o       (lfsr_q)
  );

  assign last_write = ({1'b0, addr_q} == (seq_len_q - LEN_W'(1)));

  always_ff @(posedge clk_sys_i) begin
    if (!rst_b_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      seq_len_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      seq_len_q <= seq_len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (go_gen_i)   state_d = ST_WRITE;
      ST_WRITE: if (last_write) state_d = ST_DONE;
      ST_DONE:  if (!go_gen_i)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Length is captured only on the accepting edge so later Diff changes are ignored.
  always_comb begin
    addr_d    = addr_q;
    seq_len_d = seq_len_q;
    if (state_q == ST_IDLE && go_gen_i) begin
      addr_d    = '0;
      seq_len_d = LEN_W'(calc_len(diff_i));
    end else if (state_q == ST_WRITE) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_comb begin
    fin_gen_o   = 1'b0;
    ram_wr_en_o = 1'b0;
    ram_addr_o  = '0;
    ram_data_o  = '0;
    case (state_q)
      ST_WRITE: begin
        ram_wr_en_o = 1'b1;
        ram_addr_o  = addr_q;
        ram_data_o  = DIGIT_W'(lfsr_digit(lfsr_q));
      end
      ST_DONE: fin_gen_o = 1'b1;
      default: ;
    endcase
  end

  assign seq_len_o = seq_len_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: vector table, hand-written corner
// sequences and randomized runs against a software LFSR/length model.
module tb_sequence_generator;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       go;
  logic [3:0] diff;
  logic       fin_gen;
  logic       wr_en;
  logic [4:0] addr;
  logic [3:0] data;
  logic [5:0] seq_len;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] m_lfsr = SEED;

  always #5 clk = ~clk;

  sequence_generator #(
    .ADDR_W  (5),
    .DIGIT_W (4),
    .SEED    (SEED)
  ) dut (
    .clk_sys_i   (clk),
    .rst_b_i     (rst_b),
    .go_gen_i    (go),
    .diff_i      (diff),
    .fin_gen_o   (fin_gen),
    .ram_wr_en_o (wr_en),
    .ram_addr_o  (addr),
    .ram_data_o  (data),
    .seq_len_o   (seq_len)
  );

  typedef struct {
    logic [3:0] diff;
    bit         pulse;
    int         exp_len;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [15:0] ref_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [3:0] ref_digit(input logic [15:0] v);
    logic [3:0] n;
    n = v[3:0];
    return (n > 4'd9) ? n - 4'd6 : n;
  endfunction

  function automatic int ref_len(input int d);
    int l;
    l = 4 * (d + 1);
    return (l > 32) ? 32 : l;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [15:0] nx;
    nx = rst_b ? ref_next(m_lfsr) : SEED;
    @(posedge clk);
    #1;
    m_lfsr = nx;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({nm, "_fin"}, 32'(fin_gen), 32'd0);
  endtask

  // One full handshake: accept edge E, L writes, DONE, then back to IDLE.
  task automatic do_run(input logic [3:0] d, input bit pulse, input logic [3:0] d_mid,
                        input int exp_len);
    go   = 1'b1;
    diff = d;
    step();
    if (pulse) go = 1'b0;
    diff = d_mid;
    chk("seq_len", 32'(seq_len), 32'(exp_len));
    for (int k = 0; k < exp_len; k++) begin
      chk("wr_en", 32'(wr_en), 32'd1);
      chk("addr", 32'(addr), 32'(k));
      chk("data", 32'(data), 32'(ref_digit(m_lfsr)));
      chk("data_range", 32'(data <= 4'd9), 32'd1);
      chk("fin_early", 32'(fin_gen), 32'd0);
      step();
    end
    chk("fin_done", 32'(fin_gen), 32'd1);
    chk("wr_en_done", 32'(wr_en), 32'd0);
    chk("seq_len_hold", 32'(seq_len), 32'(exp_len));
    if (!pulse) begin
      step();
      chk("fin_hold", 32'(fin_gen), 32'd1);
      go = 1'b0;
    end
    step();
    chk_quiet("after_drop");
    step();
    chk_quiet("idle");
  endtask

  initial begin
    vecs[0] = '{diff: 4'd0,  pulse: 1'b0, exp_len: 4};
    vecs[1] = '{diff: 4'd1,  pulse: 1'b1, exp_len: 8};
    vecs[2] = '{diff: 4'd3,  pulse: 1'b0, exp_len: 16};
    vecs[3] = '{diff: 4'd6,  pulse: 1'b1, exp_len: 28};
    vecs[4] = '{diff: 4'd7,  pulse: 1'b0, exp_len: 32};
    vecs[5] = '{diff: 4'd9,  pulse: 1'b0, exp_len: 32};
    vecs[6] = '{diff: 4'd15, pulse: 1'b1, exp_len: 32};

    rst_b = 1'b0;
    go    = 1'b0;
    diff  = 4'd0;
    step();
    step();
    chk("rst_fin", 32'(fin_gen), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_seq_len", 32'(seq_len), 32'd0);
    chk("rst_lfsr", 32'(dut.u_lfsr.q_o), 32'h0000ACE1);
    rst_b = 1'b1;
    step();
    chk("lfsr_first_step", 32'(dut.u_lfsr.q_o), 32'h0000E270);
    chk("lfsr_model", 32'(dut.u_lfsr.q_o), 32'(m_lfsr));

    for (int i = 0; i < 7; i++) begin
      do_run(vecs[i].diff, vecs[i].pulse, vecs[i].diff, vecs[i].exp_len);
    end

    // Diff moves during WRITE: length must stay at the sampled value.
    do_run(4'd0, 1'b0, 4'd5, 4);

    // Reset in the middle of a 12-digit run.
    go   = 1'b1;
    diff = 4'd2;
    step();
    go = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("pre_abort_addr", 32'(addr), 32'(k));
      step();
    end
    chk("abort_at_write3", 32'(addr), 32'd3);
    rst_b = 1'b0;
    step();
    chk_quiet("abort");
    chk("abort_addr", 32'(addr), 32'd0);
    chk("abort_seq_len", 32'(seq_len), 32'd0);
    chk("abort_lfsr", 32'(dut.u_lfsr.q_o), 32'(SEED));
    rst_b = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk_quiet("post_abort");
    end
    do_run(4'd0, 1'b1, 4'd0, 4);

    for (int r = 0; r < 20; r++) begin
      int d, dm, gap;
      bit p;
      d   = int'($urandom_range(0, 15));
      dm  = int'($urandom_range(0, 15));
      gap = int'($urandom_range(0, 4));
      p   = 1'($urandom_range(0, 1));
      for (int g = 0; g < gap; g++) begin
        step();
        chk_quiet("rand_gap");
      end
      do_run(4'(d), p, 4'(dm), ref_len(d));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
